fifo_burst_rd_ctrl: RTL and testbench
=====================================

# fifo_burst_rd_ctrl

Read-side scheduler for a show-ahead synchronous FIFO. It watches the FIFO occupancy count and pops entries in bursts onto a valid/ready stream. A burst starts when the configured burst length has accumulated, or when data has waited past a timeout. It sits between the FIFO's flag/occupancy logic and the downstream consumer, and is the only agent that reads the FIFO.

## Interface
- DEEPWID, 3, log2 of FIFO depth; depth D = 2**DEEPWID
- TOWID, 8, width of the timeout counter
- GAPWID, 4, width of the inter-burst gap counter

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_en  in  1  scheduler enable
- cfg_burst_len  in  DEEPWID+1  target beats per burst
- cfg_timeout  in  TOWID  idle-wait cycles before a partial flush; 0 disables flush
- cfg_gap  in  GAPWID  minimum idle cycles after each burst
- fifo_num  in  DEEPWID+1  FIFO occupancy, 0..D
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  W (module parameter DW, default 8)  show-ahead FIFO head data
- fifo_rd_en  out  1  pop strobe; equals out_valid & out_ready
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  DW  combinational pass-through of fifo_rd_data
- out_first  out  1  first beat of a burst
- out_last  out  1  final beat of a burst
- burst_len  out  DEEPWID+1  registered length of the current or most recent burst
- flush_pulse  out  1  one-cycle pulse when a timeout burst is launched
- busy  out  1  state is not IDLE

## Operation
- Effective length L = cfg_burst_len, with 0 treated as 1 and values above D clamped to D.
- FSM states: IDLE, BURST, GAP.
- IDLE transitions:
  - If cfg_en & fifo_num >= L: go to BURST, burst_len <= L.
  - Else if cfg_en & cfg_timeout != 0 & !fifo_empty & wait_cnt == cfg_timeout: go to BURST, burst_len <= fifo_num, flush_pulse = 1.
  - The threshold condition wins over timeout when both hold.
- wait_cnt:
  - Increments in IDLE while !fifo_empty & cfg_en.
  - Saturates at its maximum value.
  - Clears when fifo_empty, when !cfg_en, and on leaving IDLE.
- BURST state:
  - out_valid = 1. Underflow is impossible because the snapshot length is at most fifo_num and no other reader exists.
  - beat_cnt counts handshakes.
  - out_first = out_valid & beat_cnt == 0.
  - out_last = out_valid & beat_cnt == burst_len-1.
  - A handshake on the last beat goes to GAP if cfg_gap != 0, else to IDLE.
- GAP state: out_valid = 0. gap_cnt counts cfg_gap cycles, then the FSM goes to IDLE.
- cfg_en low during BURST: the current burst completes. No new burst starts.
- Config changes take effect only at the next IDLE decision. burst_len is frozen for the duration of a burst.
- Reset (asynchronous, any time, including mid-burst):
  - State is IDLE and all counters are 0.
  - burst_len = 0, and out_valid, out_first, out_last, flush_pulse, fifo_rd_en, busy are all 0.
  - A burst interrupted by reset is abandoned. No partial completion is tracked.

## Timing
- The IDLE decision is registered: a condition true in cycle t gives out_valid = 1 in cycle t+1.
- Timeout timing: if data is first present in cycle t0 with fifo_num below L, the flush burst's out_valid rises at t0 + cfg_timeout + 1.
- fifo_rd_en, out_data, out_first, out_last are combinational from state, counters, out_ready and fifo_rd_data. A pop takes effect in the FIFO on the same clock edge as the handshake.
- A burst of N beats with out_ready held high occupies exactly N cycles. Backpressure stalls beat_cnt with no beat loss or duplication.
- After the last beat, out_valid stays low for exactly cfg_gap cycles plus 1 cycle of IDLE decision.
- flush_pulse is asserted for exactly the single cycle of the IDLE-to-BURST transition.

## Structure
- A shared package holds:
  - the state enum (IDLE, BURST, GAP)
  - the length clamp function (L from cfg_burst_len and DEEPWID)
- One natural sub-module is fifo_burst_timer: a saturating, clearable up-counter with a compare-equal output. It is instantiated twice, for wait_cnt and gap_cnt.
- The FSM, beat counter and output decode live in the top module.

## Test plan
- Threshold burst: DEEPWID=3, L=4, write 4 entries, ready=1 → out_valid rises the cycle after fifo_num reaches 4. Four beats in consecutive cycles with first on beat 0 and last on beat 3. burst_len=4, fifo_num returns to 0.
- Timeout flush: L=8, cfg_timeout=5, write 3 entries at t0 → flush_pulse and out_valid at t0+6, burst_len=3, three beats, last on the third.
- Backpressure: L=4, out_ready toggles 1,0,0,1,1,0,1 → exactly 4 pops, data order preserved, out_last only on the 4th accepted beat.
- Gap and back-to-back: cfg_gap=3, FIFO held full (8) with L=4 → two bursts of 4 separated by exactly 4 cycles of out_valid=0. Repeat with cfg_gap=0 → 1-cycle separation.
- Boundaries:
  - cfg_burst_len=0 gives single-beat bursts.
  - cfg_burst_len=15 clamps to 8.
  - Threshold and timeout true in the same cycle: threshold wins and flush_pulse stays 0.
  - cfg_en dropped mid-burst: the burst completes, then the FSM stays in IDLE.
- Reset mid-burst: assert rst after beat 2 of 4 → all outputs 0 immediately (asynchronous), state IDLE. After release, a new burst starts from beat_cnt=0 with out_first asserted.

Source files
------------

// File: rtl/fifo_burst_rd_ctrl_pkg.sv
// Shared types and helpers for the FIFO burst read scheduler.
//   state_t        : scheduler FSM states (IDLE, BURST, GAP)
//   eff_burst_len  : maps the configured burst length to the length actually
//                    used, where 0 becomes 1 and anything above the FIFO depth
//                    becomes the depth.
package fifo_burst_rd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int unsigned eff_burst_len(input int unsigned cfg_len,
                                                  input int unsigned deepwid);
        int unsigned depth;
        depth = 32'd1 << deepwid;
        if (cfg_len == 0)
            return 1;
        if (cfg_len > depth)
            return depth;
        return cfg_len;
    endfunction

endpackage

// File: rtl/fifo_burst_timer.sv
// Saturating, clearable up-counter with an equality compare.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count enable; the count holds once it reaches all-ones
//   cmp_val  : compare value
//   eq       : count == cmp_val
module fifo_burst_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] cmp_val,
    output logic         eq
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (inc && (cnt_reg != {W{1'b1}}))
            cnt_reg <= cnt_reg + W'(1);
    end

    assign eq = (cnt_reg == cmp_val);

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst scheduler for a show-ahead synchronous FIFO.
// It watches the FIFO occupancy and pops bursts onto a valid/ready stream.
// A burst is launched when the effective burst length is available, or when
// data has waited cfg_timeout cycles. In the timeout case the burst is a
// partial flush of whatever is present.
//   cfg_en / cfg_burst_len / cfg_timeout / cfg_gap : run-time configuration
//   fifo_num / fifo_empty / fifo_rd_data           : FIFO status and head data
//   fifo_rd_en                                     : pop strobe (== handshake)
//   out_valid / out_ready / out_data               : output stream
//   out_first / out_last                           : burst framing
//   burst_len                                      : length of current/last burst
//   flush_pulse                                    : first cycle of a timeout burst
//   busy                                           : FSM not idle
module fifo_burst_rd_ctrl
    import fifo_burst_rd_ctrl_pkg::*;
#(
    parameter int DEEPWID = 3,
    parameter int TOWID   = 8,
    parameter int GAPWID  = 4,
    parameter int DW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_en,
    input  logic [DEEPWID:0]   cfg_burst_len,
    input  logic [TOWID-1:0]   cfg_timeout,
    input  logic [GAPWID-1:0]  cfg_gap,
    input  logic [DEEPWID:0]   fifo_num,
    input  logic               fifo_empty,
    input  logic [DW-1:0]      fifo_rd_data,
    output logic               fifo_rd_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic               out_first,
    output logic               out_last,
    output logic [DEEPWID:0]   burst_len,
    output logic               flush_pulse,
    output logic               busy
);

    localparam int CW = DEEPWID + 1;

    state_t          state_reg, state_next;
    logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [CW-1:0]   burst_len_reg, burst_len_next;
    logic            flush_reg, flush_next;

    logic [CW-1:0]   eff_len;
    logic            thresh_hit;
    logic            timeout_hit;
    logic            wait_eq;
    logic            gap_done;
    logic            handshake;
    logic            last_beat;

    assign eff_len = CW'(eff_burst_len(32'(cfg_burst_len), DEEPWID));

    assign thresh_hit  = cfg_en && (fifo_num >= eff_len);
    // Only reachable when the threshold is not met; the IDLE decision gives
    // the threshold priority.
    assign timeout_hit = cfg_en && (cfg_timeout != '0) && !fifo_empty && wait_eq;

    assign out_valid  = (state_reg == ST_BURST);
    assign handshake  = out_valid && out_ready;
    assign last_beat  = (beat_cnt_reg == (burst_len_reg - CW'(1)));

    assign fifo_rd_en  = handshake;
    assign out_data    = fifo_rd_data;
    assign out_first   = out_valid && (beat_cnt_reg == '0);
    assign out_last    = out_valid && last_beat;
    assign burst_len   = burst_len_reg;
    assign flush_pulse = flush_reg;
    assign busy        = (state_reg != ST_IDLE);

    // Wait counter: measures how long data has been sitting while idle.
    // Restarts whenever the FIFO drains, the scheduler is disabled, or a
    // burst is launched.
    fifo_burst_timer #(.W(TOWID)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state_reg != ST_IDLE) || (state_next != ST_IDLE) || fifo_empty || !cfg_en),
        .inc     ((state_reg == ST_IDLE) && !fifo_empty && cfg_en),
        .cmp_val (cfg_timeout),
        .eq      (wait_eq)
    );

    // Gap counter: GAP is entered with the count at 0, so the last GAP
    // cycle is the one where the count equals cfg_gap-1. GAP is never
    // entered with cfg_gap == 0, so the wrapped compare value is harmless.
    fifo_burst_timer #(.W(GAPWID)) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((state_reg != ST_GAP) || gap_done),
        .inc     (state_reg == ST_GAP),
        .cmp_val (cfg_gap - GAPWID'(1)),
        .eq      (gap_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            beat_cnt_reg  <= '0;
            burst_len_reg <= '0;
            flush_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            burst_len_reg <= burst_len_next;
            flush_reg     <= flush_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        burst_len_next = burst_len_reg;
        flush_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (thresh_hit) begin
                    state_next     = ST_BURST;
                    beat_cnt_next  = '0;
                    burst_len_next = eff_len;
                end else if (timeout_hit) begin
                    state_next     = ST_BURST;
                    beat_cnt_next  = '0;
                    burst_len_next = fifo_num;
                    flush_next     = 1'b1;
                end
            end
            ST_BURST: begin
                // cfg_en is deliberately ignored here: a started burst
                // always runs to completion.
                if (handshake) begin
                    if (last_beat) begin
                        beat_cnt_next = '0;
                        state_next    = (cfg_gap != '0) ? ST_GAP : ST_IDLE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_done)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
module tb_fifo_burst_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [3:0]  cfg_burst_len;
    logic [7:0]  cfg_timeout;
    logic [3:0]  cfg_gap;
    logic [3:0]  fifo_num;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_first;
    logic        out_last;
    logic [3:0]  burst_len;
    logic        flush_pulse;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_burst_rd_ctrl #(.DEEPWID(3), .TOWID(8), .GAPWID(4), .DW(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_en        (cfg_en),
        .cfg_burst_len (cfg_burst_len),
        .cfg_timeout   (cfg_timeout),
        .cfg_gap       (cfg_gap),
        .fifo_num      (fifo_num),
        .fifo_empty    (fifo_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_first     (out_first),
        .out_last      (out_last),
        .burst_len     (burst_len),
        .flush_pulse   (flush_pulse),
        .busy          (busy)
    );

    // Behavioural show-ahead FIFO, depth 8
    logic [7:0] mem [8];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         count  = 0;
    logic       push;
    logic [7:0] push_data;
    logic       fifo_clr;
    logic       do_push;

    assign do_push      = push && ((count < 8) || fifo_rd_en);
    assign fifo_num     = 4'(count);
    assign fifo_empty   = (count == 0);
    assign fifo_rd_data = mem[rd_ptr[2:0]];

    always @(posedge clk) begin
        if (fifo_clr) begin
            wr_ptr <= 0;
            rd_ptr <= 0;
            count  <= 0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[2:0]] <= push_data;
                wr_ptr <= (wr_ptr + 1) % 8;
            end
            if (fifo_rd_en)
                rd_ptr <= (rd_ptr + 1) % 8;
            count <= count + (do_push ? 1 : 0) - (fifo_rd_en ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            push      = 1'b1;
            push_data = base + 8'(i);
            tick();
            $display("push data=%0h count=%0d", push_data, count);
        end
        push = 1'b0;
    endtask

    task automatic cleanup();
        push      = 1'b0;
        cfg_en    = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
    endtask

    logic [6:0]  pat;
    int          pops;
    logic [11:0] seen12;
    logic [11:0] exp12;
    logic [8:0]  seen9;
    logic [8:0]  exp9;

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_burst_len = 4'd4; cfg_timeout = 8'd0;
        cfg_gap = 4'd0; out_ready = 1'b1; push = 1'b0; push_data = 8'h00; fifo_clr = 1'b0;
        repeat (2) tick();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_burst_len", burst_len, 0);
        check("rst_flush", flush_pulse, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_first", out_first, 0);
        check("rst_last", out_last, 0);
        rst = 1'b0;
        tick();

        // Threshold burst of 4
        cfg_en = 1'b1; cfg_burst_len = 4'd4;
        fill(4, 8'h10);
        check("thr_decide_valid", out_valid, 0);
        check("thr_decide_num", fifo_num, 4);
        tick();
        check("thr_burst_len", burst_len, 4);
        check("thr_flush", flush_pulse, 0);
        for (int i = 0; i < 4; i++) begin
            check("thr_valid", out_valid, 1);
            check("thr_data", out_data, 32'h10 + 32'(i));
            check("thr_first", out_first, (i == 0) ? 1 : 0);
            check("thr_last", out_last, (i == 3) ? 1 : 0);
            $display("thr beat %0d data=%0h first=%0b last=%0b", i, out_data, out_first, out_last);
            tick();
        end
        check("thr_after_valid", out_valid, 0);
        check("thr_after_busy", busy, 0);
        check("thr_after_num", fifo_num, 0);

        // Timeout flush: L=8, timeout=5, 3 entries
        cfg_burst_len = 4'd8; cfg_timeout = 8'd5;
        push = 1'b1; push_data = 8'h20; tick();   // t0
        push_data = 8'h21; tick();
        push_data = 8'h22; tick();                // t0+2
        push = 1'b0;
        repeat (3) tick();                        // t0+5
        check("to_t5_valid", out_valid, 0);
        tick();                                   // t0+6
        check("to_valid", out_valid, 1);
        check("to_flush", flush_pulse, 1);
        check("to_burst_len", burst_len, 3);
        check("to_first", out_first, 1);
        check("to_data0", out_data, 32'h20);
        tick();
        check("to_flush_drop", flush_pulse, 0);
        check("to_data1", out_data, 32'h21);
        check("to_last1", out_last, 0);
        tick();
        check("to_data2", out_data, 32'h22);
        check("to_last2", out_last, 1);
        tick();
        check("to_after_valid", out_valid, 0);
        $display("timeout flush done, num=%0d", fifo_num);
        cfg_timeout = 8'd0;

        // Backpressure: ready 1,0,0,1,1,0,1
        cfg_burst_len = 4'd4;
        fill(4, 8'h30);
        tick();
        pat  = 7'b1011001;
        pops = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            #1;
            check("bp_valid", out_valid, 1);
            if (fifo_rd_en) begin
                check("bp_data", out_data, 32'h30 + 32'(pops));
                check("bp_last", out_last, (pops == 3) ? 1 : 0);
                $display("bp accept %0d data=%0h last=%0b", pops, out_data, out_last);
                pops++;
            end
            tick();
        end
        check("bp_pops", pops, 4);
        check("bp_after_valid", out_valid, 0);
        check("bp_after_num", fifo_num, 0);
        out_ready = 1'b1;

        // Gap 3 with FIFO held full
        cfg_en = 1'b0; cfg_gap = 4'd3; cfg_burst_len = 4'd4;
        fill(8, 8'h40);
        push = 1'b1; cfg_en = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            seen12[i] = out_valid;
            tick();
        end
        exp12 = 12'b1111_0000_1111;
        check("gap3_pattern", seen12, exp12);
        $display("gap3 valid pattern=%b", seen12);
        cleanup();

        // Gap 0 back-to-back
        cfg_gap = 4'd0;
        fill(8, 8'h50);
        push = 1'b1; cfg_en = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            seen9[i] = out_valid;
            tick();
        end
        exp9 = 9'b1111_0_1111;
        check("gap0_pattern", seen9, exp9);
        $display("gap0 valid pattern=%b", seen9);
        cleanup();

        // cfg_burst_len = 0 -> single-beat bursts
        cfg_burst_len = 4'd0;
        fill(2, 8'h60);
        cfg_en = 1'b1;
        tick();
        check("len0_valid", out_valid, 1);
        check("len0_first", out_first, 1);
        check("len0_last", out_last, 1);
        check("len0_burst_len", burst_len, 1);
        check("len0_data", out_data, 32'h60);
        tick();
        check("len0_idle_valid", out_valid, 0);
        tick();
        check("len0_second_valid", out_valid, 1);
        check("len0_second_data", out_data, 32'h61);
        tick();
        check("len0_empty_valid", out_valid, 0);
        cleanup();

        // cfg_burst_len = 15 clamps to 8
        cfg_burst_len = 4'd15; cfg_en = 1'b1;
        fill(7, 8'h70);
        repeat (2) tick();
        check("len15_7_valid", out_valid, 0);
        fill(1, 8'h77);
        tick();
        check("len15_valid", out_valid, 1);
        check("len15_burst_len", burst_len, 8);
        cleanup();

        // Threshold and timeout true in the same cycle
        cfg_burst_len = 4'd4; cfg_timeout = 8'd3; cfg_en = 1'b1;
        fill(4, 8'h80);
        tick();
        check("tie_valid", out_valid, 1);
        check("tie_flush", flush_pulse, 0);
        check("tie_burst_len", burst_len, 4);
        cleanup();
        cfg_timeout = 8'd0;

        // cfg_en dropped mid-burst
        cfg_burst_len = 4'd2;
        fill(4, 8'h90);
        cfg_en = 1'b1;
        tick();
        check("endrop_beat0", out_valid, 1);
        cfg_en = 1'b0;
        tick();
        check("endrop_beat1_valid", out_valid, 1);
        check("endrop_beat1_last", out_last, 1);
        check("endrop_beat1_data", out_data, 32'h91);
        tick();
        check("endrop_after_valid", out_valid, 0);
        repeat (3) tick();
        check("endrop_idle_valid", out_valid, 0);
        check("endrop_idle_busy", busy, 0);
        check("endrop_num", fifo_num, 2);
        cleanup();

        // Asynchronous reset mid-burst
        cfg_burst_len = 4'd4;
        fill(4, 8'hA0);
        cfg_en = 1'b1;
        tick();
        tick();
        tick();
        check("rstmid_pre_data", out_data, 32'hA2);
        rst = 1'b1;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_first", out_first, 0);
        check("rstmid_last", out_last, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_burst_len", burst_len, 0);
        check("rstmid_rd_en", fifo_rd_en, 0);
        check("rstmid_flush", flush_pulse, 0);
        tick();
        rst = 1'b0;
        check("rstmid_num", fifo_num, 2);
        fill(2, 8'hA4);
        tick();
        check("rstnew_valid", out_valid, 1);
        check("rstnew_first", out_first, 1);
        check("rstnew_last", out_last, 0);
        check("rstnew_data", out_data, 32'hA2);
        check("rstnew_burst_len", burst_len, 4);
        cleanup();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
